mssd_tx_scheduler: RTL and testbench

MSSD_TX_SCHEDULER -- requirements
Module: mssd_tx_scheduler

---
 rtl/mssd_pkg.sv | 24 ++
 rtl/mssd_rr_arbiter.sv | 27 ++
 rtl/mssd_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mssd_tx_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mssd_pkg.sv
// rtl/mssd_pkg.sv - shared widths and frame state encoding for the MSSD serial transmitter
package mssd_pkg;

   localparam int NUM_CH = 4;
   localparam int DEST_W = 2;
   localparam int LEN_W  = 4;
   localparam int BYTE_W = 8;
   localparam int CNT_W  = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DEST  = 3'd2,
      LEN   = 3'd3,
      DATA  = 3'd4,
      GAP   = 3'd5
   } mssd_state_e;

   // Number of payload bits carried by a frame of the given byte count.
   function automatic logic [CNT_W-1:0] data_bits(input logic [LEN_W-1:0] n_bytes);
      return {n_bytes, 3'b000};
   endfunction

endpackage

// File: rtl/mssd_rr_arbiter.sv
// rtl/mssd_rr_arbiter.sv - round-robin channel picker starting after the last winner
module mssd_rr_arbiter
   import mssd_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [DEST_W-1:0] pointer,
   output logic [NUM_CH-1:0] grant,
   output logic [DEST_W-1:0] index
);

   logic [DEST_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester is assigned last.
   always_comb begin
      grant = '0;
      index = pointer;
      cand  = pointer;
      for (int off = NUM_CH; off >= 1; off--) begin
         cand = pointer + DEST_W'(off);
         if (req[cand]) begin
            grant = NUM_CH'(1) << cand;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/mssd_tx_scheduler.sv
// rtl/mssd_tx_scheduler.sv - arbitrates four channels and serialises one framed transfer at a time
module mssd_tx_scheduler
   import mssd_pkg::*;
#(
   parameter int IDLE_GAP = 1
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH*LEN_W-1:0]  len,
   input  logic [NUM_CH*BYTE_W-1:0] data,
   output logic [NUM_CH-1:0]        byte_ack,
   output logic [NUM_CH-1:0]        grant,
   output logic                     serOut,
   output logic                     busy,
   output logic                     frame_done
);

   mssd_state_e       state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DEST_W-1:0] ch_idx, ch_n;
   logic [LEN_W-1:0]  len_q, len_n;
   logic [DEST_W-1:0] rr_ptr, ptr_n;
   logic [BYTE_W-1:0] shreg, shreg_n;

   logic              ser_n, busy_n, fd_n;
   logic [NUM_CH-1:0] ack_n, grant_n;

   logic [NUM_CH-1:0] arb_grant;
   logic [DEST_W-1:0] arb_index;
   logic [DEST_W-1:0] dest_sh;
   logic [LEN_W-1:0]  len_sh;
   logic [BYTE_W-1:0] sel_byte;

   mssd_rr_arbiter u_arb (
      .req     (req),
      .pointer (rr_ptr),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   // Every output is the registered value for the cycle that follows the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         ch_idx     <= '0;
         len_q      <= '0;
         rr_ptr     <= DEST_W'(NUM_CH - 1);
         shreg      <= '0;
         serOut     <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         byte_ack   <= '0;
         grant      <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         ch_idx     <= ch_n;
         len_q      <= len_n;
         rr_ptr     <= ptr_n;
         shreg      <= shreg_n;
         serOut     <= ser_n;
         busy       <= busy_n;
         frame_done <= fd_n;
         byte_ack   <= ack_n;
         grant      <= grant_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ch_n    = ch_idx;
      len_n   = len_q;
      ptr_n   = rr_ptr;
      case (state)
         IDLE: begin
            if (|arb_grant) begin
               state_n = START;
               cnt_n   = '0;
               ch_n    = arb_index;
               len_n   = len[LEN_W*arb_index +: LEN_W];
               ptr_n   = arb_index;
            end
         end
         START: begin
            state_n = DEST;
            cnt_n   = '0;
         end
         DEST: begin
            if (cnt == CNT_W'(DEST_W - 1)) begin
               state_n = LEN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         LEN: begin
            if (cnt == CNT_W'(LEN_W - 1)) begin
               state_n = (len_q != '0) ? DATA : GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == data_bits(len_q) - CNT_W'(1)) begin
               state_n = GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == CNT_W'(IDLE_GAP - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Header bits are picked MSB-first by shifting the field left by the bit position.
   always_comb begin
      dest_sh  = ch_n << cnt_n;
      len_sh   = len_n << cnt_n;
      sel_byte = data[BYTE_W*ch_n +: BYTE_W];
      ser_n    = 1'b1;
      shreg_n  = shreg;
      ack_n    = '0;
      fd_n     = 1'b0;
      busy_n   = (state_n != IDLE);
      if (state == IDLE && state_n == START) begin
         grant_n = arb_grant;
      end else if (busy_n) begin
         grant_n = NUM_CH'(1) << ch_n;
      end else begin
         grant_n = '0;
      end
      case (state_n)
         START: ser_n = 1'b0;
         DEST:  ser_n = dest_sh[DEST_W-1];
         LEN: begin
            ser_n = len_sh[LEN_W-1];
            fd_n  = (cnt_n == CNT_W'(LEN_W - 1)) && (len_n == '0);
         end
         DATA: begin
            if (cnt_n[2:0] == 3'd0) begin
               shreg_n = sel_byte;
               ack_n   = NUM_CH'(1) << ch_n;
            end else begin
               shreg_n = shreg << 1;
            end
            ser_n = shreg_n[BYTE_W-1];
            fd_n  = (cnt_n == data_bits(len_n) - CNT_W'(1));
         end
         default: ser_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mssd_tx_scheduler.sv
// tb/tb_mssd_tx_scheduler.sv - self-checking bench for the MSSD transmit scheduler
module tb_mssd_tx_scheduler;

   localparam int GAP = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] len;
   logic [31:0] data;
   logic [3:0]  byte_ack;
   logic [3:0]  grant;
   logic        serOut;
   logic        busy;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] byte_mem [4][16];
   int         idx [4];
   int         rr_last;

   int           cap_wait, cap_n, cap_ack_bad, cap_g_bad, cap_idle_bad;
   logic [255:0] cap_bits, cap_fd, cap_ack;
   logic [3:0]   cap_g0;
   int           exp_n;
   logic [255:0] exp_bits, exp_fd, exp_ack;

   always #5 clk = ~clk;

   mssd_tx_scheduler #(.IDLE_GAP(GAP)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .len        (len),
      .data       (data),
      .byte_ack   (byte_ack),
      .grant      (grant),
      .serOut     (serOut),
      .busy       (busy),
      .frame_done (frame_done)
   );

   function automatic int rr_pick(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(rr_last + k) % 4]) return (rr_last + k) % 4;
      end
      return -1;
   endfunction

   task automatic load_channel(input int c, input int ln, input bit rnd, input logic [7:0] b0, input logic [7:0] b1);
      logic [3:0] lv;
      lv = ln[3:0];
      for (int k = 0; k < 16; k++) byte_mem[c][k] = rnd ? 8'($urandom) : b0;
      if (!rnd) byte_mem[c][1] = b1;
      idx[c] = 0;
      len[4*c +: 4] = lv;
      data[8*c +: 8] = byte_mem[c][0];
   endtask

   // Expected line content while busy: frame bits then GAP idle-high bits.
   task automatic model(input int ch, input int ln, input int first);
      logic [1:0] chv;
      logic [3:0] lv;
      logic [7:0] b;
      chv = ch[1:0];
      lv  = ln[3:0];
      exp_bits = '0; exp_fd = '0; exp_ack = '0;
      exp_bits[0] = 1'b0;
      exp_bits[1] = chv[1];
      exp_bits[2] = chv[0];
      for (int i = 0; i < 4; i++) exp_bits[3+i] = lv[3-i];
      exp_n = 7;
      for (int k = 0; k < ln; k++) begin
         b = byte_mem[ch][first+k];
         exp_ack[exp_n] = 1'b1;
         for (int i = 0; i < 8; i++) begin
            exp_bits[exp_n] = b[7-i];
            exp_n++;
         end
      end
      exp_fd[exp_n-1] = 1'b1;
      for (int i = 0; i < GAP; i++) begin
         exp_bits[exp_n] = 1'b1;
         exp_n++;
      end
   endtask

   task automatic capture(input bit keep_req, input bit scramble);
      cap_wait = 0; cap_n = 0; cap_ack_bad = 0; cap_g_bad = 0; cap_idle_bad = 0;
      cap_bits = '0; cap_fd = '0; cap_ack = '0; cap_g0 = '0;
      while (busy !== 1'b1 && cap_wait < 50) begin
         if (serOut !== 1'b1) cap_idle_bad++;
         @(negedge clk);
         cap_wait++;
      end
      while (busy === 1'b1 && cap_n < 250) begin
         cap_bits[cap_n] = serOut;
         cap_fd[cap_n]   = frame_done;
         cap_ack[cap_n]  = |byte_ack;
         if (cap_n == 0) begin
            cap_g0 = grant;
            if (!keep_req) req = '0;
         end else if (grant !== cap_g0) begin
            cap_g_bad++;
         end
         if (byte_ack !== 4'b0 && byte_ack !== cap_g0) cap_ack_bad++;
         if (scramble && cap_n == 3) begin
            len = 16'($urandom);
            for (int c = 0; c < 4; c++) if (!cap_g0[c]) data[8*c +: 8] = 8'($urandom);
         end
         for (int c = 0; c < 4; c++) begin
            if (byte_ack[c]) begin
               if (idx[c] < 15) idx[c]++;
               data[8*c +: 8] = byte_mem[c][idx[c]];
            end
         end
         cap_n++;
         @(negedge clk);
      end
   endtask

   task automatic check_frame_inline_guard;
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; len = '0; data = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({serOut, grant, byte_ack, busy, frame_done} !== {1'b1, 4'b0, 4'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs got ser=%b grant=%b ack=%b busy=%b fd=%b exp 1 0000 0000 0 0", serOut, grant, byte_ack, busy, frame_done);
      end
      reset = 1'b0;
      rr_last = 3;
      @(negedge clk);
      total++;
      if (serOut !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset got ser=%b busy=%b exp 1 0", serOut, busy);
      end
   endtask

   task automatic test_basic;
      load_channel(0, 2, 0, 8'hA5, 8'h3C);
      req = 4'b0001;
      model(0, 2, 0);
      capture(0, 0);
      rr_last = 0;
      total++; if (cap_wait !== 1 || cap_idle_bad != 0) begin bad++; $display("FAIL basic_latency got %0d idle_bad=%0d exp 1", cap_wait, cap_idle_bad); end
      total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL basic_bits got n=%0d %h exp n=%0d %h", cap_n, cap_bits, exp_n, exp_bits); end
      total++; if (cap_fd !== exp_fd) begin bad++; $display("FAIL basic_frame_done got %h exp %h", cap_fd, exp_fd); end
      total++; if (cap_ack !== exp_ack || cap_ack_bad != 0) begin bad++; $display("FAIL basic_byte_ack got %h bad=%0d exp %h", cap_ack, cap_ack_bad, exp_ack); end
      total++; if (cap_g0 !== 4'b0001 || cap_g_bad != 0) begin bad++; $display("FAIL basic_grant got %b bad=%0d exp 0001", cap_g0, cap_g_bad); end
   endtask

   task automatic test_len_zero;
      load_channel(2, 0, 1, 8'h00, 8'h00);
      req = 4'b0100;
      model(2, 0, 0);
      capture(0, 0);
      rr_last = 2;
      total++; if (cap_wait !== 1 || cap_idle_bad != 0) begin bad++; $display("FAIL len0_latency got %0d idle_bad=%0d exp 1", cap_wait, cap_idle_bad); end
      total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL len0_bits got n=%0d %h exp n=%0d %h", cap_n, cap_bits, exp_n, exp_bits); end
      total++; if (cap_fd !== exp_fd) begin bad++; $display("FAIL len0_frame_done got %h exp %h", cap_fd, exp_fd); end
      total++; if (cap_ack !== '0 || cap_ack_bad != 0) begin bad++; $display("FAIL len0_byte_ack got %h bad=%0d exp 0", cap_ack, cap_ack_bad); end
      total++; if (cap_g0 !== 4'b0100 || cap_g_bad != 0) begin bad++; $display("FAIL len0_grant got %b bad=%0d exp 0100", cap_g0, cap_g_bad); end
   endtask

   task automatic test_back_to_back;
      int ch;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rr_last = 3;
      for (int c = 0; c < 4; c++) load_channel(c, 1, 1, 8'h00, 8'h00);
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         ch = f % 4;
         model(ch, 1, idx[ch]);
         capture(f < 4, 0);
         rr_last = ch;
         total++; if (cap_wait !== 1 || cap_idle_bad != 0) begin bad++; $display("FAIL b2b_spacing frame %0d got %0d idle_bad=%0d exp 1", f, cap_wait, cap_idle_bad); end
         total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL b2b_bits frame %0d got n=%0d %h exp n=%0d %h", f, cap_n, cap_bits, exp_n, exp_bits); end
         total++; if (cap_fd !== exp_fd || cap_ack !== exp_ack || cap_ack_bad != 0) begin bad++; $display("FAIL b2b_fd_ack frame %0d got fd=%h ack=%h exp fd=%h ack=%h", f, cap_fd, cap_ack, exp_fd, exp_ack); end
         total++; if (cap_g0 !== 4'(1 << ch) || cap_g_bad != 0) begin bad++; $display("FAIL b2b_grant frame %0d got %b bad=%0d exp ch%0d", f, cap_g0, cap_g_bad, ch); end
      end
   endtask

   task automatic test_len15;
      load_channel(3, 15, 0, 8'hFF, 8'hFF);
      req = 4'b1000;
      model(3, 15, 0);
      capture(0, 1);
      rr_last = 3;
      total++; if (cap_n !== 127 + GAP || cap_bits !== exp_bits) begin bad++; $display("FAIL len15_bits got n=%0d %h exp n=%0d %h", cap_n, cap_bits, 127 + GAP, exp_bits); end
      total++; if (cap_fd !== exp_fd) begin bad++; $display("FAIL len15_frame_done got %h exp %h", cap_fd, exp_fd); end
      total++; if (cap_ack !== exp_ack || $countones(cap_ack) != 15 || cap_ack_bad != 0) begin bad++; $display("FAIL len15_byte_ack got %h bad=%0d exp %h", cap_ack, cap_ack_bad, exp_ack); end
      total++; if (cap_g0 !== 4'b1000 || cap_g_bad != 0) begin bad++; $display("FAIL len15_grant got %b bad=%0d exp 1000", cap_g0, cap_g_bad); end
   endtask

   task automatic test_req_drop;
      load_channel(1, 3, 1, 8'h00, 8'h00);
      req = 4'b0010;
      model(1, 3, 0);
      capture(0, 0);
      rr_last = 1;
      total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL drop_bits got n=%0d %h exp n=%0d %h", cap_n, cap_bits, exp_n, exp_bits); end
      total++; if (cap_fd !== exp_fd || cap_ack !== exp_ack || cap_ack_bad != 0) begin bad++; $display("FAIL drop_fd_ack got fd=%h ack=%h exp fd=%h ack=%h", cap_fd, cap_ack, exp_fd, exp_ack); end
   endtask

   task automatic test_reset_mid_frame;
      int w;
      int stray;
      load_channel(1, 4, 1, 8'h00, 8'h00);
      req = 4'b0010;
      w = 0;
      while (busy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      req = '0;
      repeat (15) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({serOut, grant, byte_ack, busy, frame_done} !== {1'b1, 4'b0, 4'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got ser=%b grant=%b ack=%b busy=%b fd=%b exp 1 0000 0000 0 0", serOut, grant, byte_ack, busy, frame_done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rr_last = 3;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || byte_ack !== 4'b0 || busy !== 1'b0 || serOut !== 1'b1) stray++;
      end
      total++; if (stray != 0) begin bad++; $display("FAIL abort_quiet got %0d active cycles exp 0", stray); end
      for (int c = 0; c < 4; c++) load_channel(c, 0, 1, 8'h00, 8'h00);
      req = 4'b1111;
      model(0, 0, 0);
      capture(0, 0);
      rr_last = 0;
      total++; if (cap_g0 !== 4'b0001 || cap_g_bad != 0) begin bad++; $display("FAIL post_reset_grant got %b exp 0001", cap_g0); end
      total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL post_reset_bits got n=%0d %h exp n=%0d %h", cap_n, cap_bits, exp_n, exp_bits); end
   endtask

   task automatic test_random;
      logic [3:0] r;
      int ch;
      int ln;
      for (int it = 0; it < 20; it++) begin
         r = 4'($urandom_range(1, 15));
         for (int c = 0; c < 4; c++) load_channel(c, $urandom_range(0, 6), 1, 8'h00, 8'h00);
         ch = rr_pick(r);
         ln = int'(len[4*ch +: 4]);
         req = r;
         model(ch, ln, 0);
         capture(0, 1);
         rr_last = ch;
         total++; if (cap_wait !== 1 || cap_idle_bad != 0) begin bad++; $display("FAIL rand_latency it %0d got %0d exp 1", it, cap_wait); end
         total++; if (cap_n !== exp_n || cap_bits !== exp_bits) begin bad++; $display("FAIL rand_bits it %0d got n=%0d %h exp n=%0d %h", it, cap_n, cap_bits, exp_n, exp_bits); end
         total++; if (cap_fd !== exp_fd || cap_ack !== exp_ack || cap_ack_bad != 0) begin bad++; $display("FAIL rand_fd_ack it %0d got fd=%h ack=%h exp fd=%h ack=%h", it, cap_fd, cap_ack, exp_fd, exp_ack); end
         total++; if (cap_g0 !== 4'(1 << ch) || cap_g_bad != 0) begin bad++; $display("FAIL rand_grant it %0d req=%b got %b exp ch%0d", it, r, cap_g0, ch); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_back_to_back();
      test_len15();
      test_req_drop();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
